// File: rtl/ifu.sv
// ifu: RV64 instruction fetch unit. Fetches one 32-bit instruction per
// 64-bit memory access, buffers results in a small FIFO and handles redirects.
// Ports: clk, rst_n (async, active-low); imem_req_* fetch request channel;
// imem_resp_* response channel; redirect_* from execute; inst_* to decode.
// Optional build macro IFU_PERF_EN adds perf_fetch_cnt / perf_flush_cnt.
module ifu #(
  parameter logic [63:0] RESET_PC   = 64'h0000000080000000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [63:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
`ifdef IFU_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_flush_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DISC
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [63:0]   r_fetch_pc;
  logic [63:0]   r_req_pc;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_cnt;
  logic [31:0]   r_mem_inst [FIFO_DEPTH];
  logic [63:0]   r_mem_pc   [FIFO_DEPTH];

  logic          w_acc;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_half;

  assign imem_req_valid = (r_state == S_REQ) && (r_cnt < DEPTH_C);
  assign imem_req_addr  = {r_fetch_pc[63:3], 3'b000};
  assign w_acc  = imem_req_valid & imem_req_ready;
  assign w_push = (r_state == S_WAIT) & imem_resp_valid & ~redirect_valid;
  assign w_pop  = inst_valid & inst_ready;
  assign w_half = r_req_pc[2] ? imem_resp_data[63:32]
                              : imem_resp_data[31:0];

  assign inst_valid = (r_cnt != '0);
  assign inst       = inst_valid ? r_mem_inst[r_rptr] : 32'd0;
  assign inst_pc    = inst_valid ? r_mem_pc[r_rptr]   : 64'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_acc)
          w_state_nxt = redirect_valid ? S_DISC : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid)
          w_state_nxt = imem_resp_valid ? S_REQ : S_DISC;
        else if (imem_resp_valid)
          w_state_nxt = S_REQ;
      end
      // The stale response retires DISCARD; a redirect while still
      // waiting for it only retargets fetch_pc.
      S_DISC: begin
        if (imem_resp_valid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
    end else begin
      if (redirect_valid)
        r_fetch_pc <= {redirect_pc[63:2], 2'b00};
      else if (w_push)
        r_fetch_pc <= r_req_pc + 64'd4;
      if (w_acc)
        r_req_pc <= r_fetch_pc;
      if (redirect_valid) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        unique case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only visible when counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wptr] <= w_half;
      r_mem_pc[r_wptr]   <= r_req_pc;
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 64'd0;
      perf_flush_cnt <= 64'd0;
    end else begin
      if (w_push)         perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 64'h0000000080000000, SHALL be the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, SHALL be the instruction buffer depth (legal values 2 and 4).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_ready  in  1  memory accepts request.
REQ-007 imem_req_addr  out  64  8-byte-aligned fetch address.
REQ-008 imem_resp_valid  in  1  response data valid.
REQ-009 imem_resp_data  in  64  fetched doubleword.
REQ-010 redirect_valid  in  1  branch/jump redirect from execute.
REQ-011 redirect_pc  in  64  redirect target.
REQ-012 inst_valid  out  1  instruction available to decode.
REQ-013 inst_ready  in  1  decode accepts instruction.
REQ-014 inst  out  32  instruction word.
REQ-015 inst_pc  out  64  address of inst.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT and DISCARD.
REQ-017 IDLE SHALL go to REQ on the first clock after reset release.
REQ-018 Issue condition: in REQ, imem_req_valid SHALL be 1 only while (FIFO count) < FIFO_DEPTH.
REQ-019 imem_req_addr SHALL equal {fetch_pc[63:3],3'b000}.
REQ-020 Accept: imem_req_valid & imem_req_ready SHALL latch fetch_pc[2] and fetch_pc, then move to WAIT.
REQ-021 The block SHALL keep at most one request outstanding.
REQ-022 A response in WAIT SHALL push {fetch_pc, half-select} into the FIFO and advance fetch_pc by 4.
REQ-023 The half-select SHALL be imem_resp_data[63:32] when the latched pc[2]=1, else [31:0].
REQ-024 After a push, the FSM SHALL return to REQ.
REQ-025 Latency: a response in cycle t SHALL give inst_valid=1 in cycle t+1.
REQ-026 inst and inst_pc SHALL come from the FIFO head.
REQ-027 The FIFO SHALL pop on inst_valid & inst_ready.
REQ-028 Push and pop in the same cycle SHALL leave the count unchanged.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 A full FIFO SHALL hold imem_req_valid=0 and keep fetch_pc unchanged.
REQ-031 An empty FIFO SHALL force inst_valid=0.
REQ-032 fetch_pc arithmetic SHALL be 64-bit and wrap silently at 2^64.
REQ-033 Redirect has highest priority: it SHALL empty the FIFO, so inst_valid=0 next cycle.
REQ-034 On redirect, fetch_pc SHALL load {redirect_pc[63:2],2'b00}.
REQ-035 Redirect in REQ without accept: the next cycle SHALL present the new address; changing imem_req_addr while unaccepted is permitted.
REQ-036 Redirect coincident with an accept, or redirect in WAIT: the FSM SHALL go to DISCARD.
REQ-037 DISCARD SHALL drop the stale response, then go to REQ.
REQ-038 Redirect in WAIT coincident with imem_resp_valid: the response SHALL be dropped and the FSM SHALL go to REQ.
REQ-039 Redirect in DISCARD SHALL stay in DISCARD and update fetch_pc.
REQ-040 Redirect coincident with a decode handshake: the pop SHALL occur and the flush SHALL still apply.
REQ-041 imem_resp_valid in IDLE or REQ SHALL be ignored.

Reset
REQ-042 While rst_n=0, state SHALL be IDLE, fetch_pc=RESET_PC and the FIFO empty.
REQ-043 While rst_n=0, imem_req_valid=0, inst_valid=0, imem_req_addr=RESET_PC aligned, inst=0 and inst_pc=0.
REQ-044 Reset asserted mid-WAIT SHALL abandon the outstanding request; a late response after release SHALL be ignored (state is IDLE/REQ).

Configuration
REQ-045 With macro IFU_PERF_EN defined, the block SHALL add perf_fetch_cnt (out 64, FIFO pushes) and perf_flush_cnt (out 64, redirect cycles).
REQ-046 Both counters SHALL reset to 0 and wrap at 2^64.
REQ-047 Without IFU_PERF_EN, these ports and counters SHALL be absent; other behaviour SHALL be identical.

Verification
REQ-048 Reset release, imem_req_ready=1, response 1 cycle after accept = 64'h00100073_00000413, inst_ready=1 -> inst_pc 0x80000000 inst 0x00000413, then inst_pc 0x80000004 inst 0x00100073.
REQ-049 inst_ready=0 for 10 cycles -> exactly FIFO_DEPTH pushes, imem_req_valid=0 afterwards, no data loss after inst_ready=1.
REQ-050 redirect_valid with redirect_pc=0x80000100 while in WAIT -> stale response dropped, next request addr 0x80000100, first inst_pc 0x80000100.
REQ-051 redirect_pc=0x80000106 -> fetch address 0x80000100, upper half selected, inst_pc 0x80000104.
REQ-052 rst_n pulled low during WAIT, response arrives after release -> no inst_valid from it, fetch restarts at 0x80000000.
REQ-053 With IFU_PERF_EN, 5 fetches and 2 redirects -> perf_fetch_cnt=5 and perf_flush_cnt=2.
